// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, FSM state encoding and helpers for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first unmasked request after 'last', wrapping 3->0.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] excl_mask,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   pick,
  output logic               found
);

  logic [NUM_REQ-1:0] cand;

  assign cand = req & ~excl_mask;

  // Offsets 1..4 from last; the 2-bit sum wraps, and offset 4 revisits last itself.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      if (!found && cand[last + SEL_W'(k)]) begin
        pick  = last + SEL_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux; registers the selected word out.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   din0,
  input  logic [WIDTH-1:0]   din1,
  input  logic [WIDTH-1:0]   din2,
  input  logic [WIDTH-1:0]   din3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  output logic               busy
);

  localparam int unsigned     HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [SEL_W-1:0]    last;

  logic [SEL_W-1:0]    pick_last;
  logic [NUM_REQ-1:0]  pick_excl;
  logic [SEL_W-1:0]    pick;
  logic                found;
  logic [WIDTH-1:0]    din_sel;

  // While granted, search resumes after the current owner and never returns to it.
  assign pick_last = (state == ST_GRANT) ? sel : last;
  assign pick_excl = (state == ST_GRANT) ? to_onehot(sel) : '0;

  rr_pick4 u_pick (
    .req       (req),
    .excl_mask (pick_excl),
    .last      (pick_last),
    .pick      (pick),
    .found     (found)
  );

  // Shared mux datapath, same select semantics as mux_4.
  always_comb begin
    din_sel = din0;
    case (sel)
      2'd0:    din_sel = din0;
      2'd1:    din_sel = din1;
      2'd2:    din_sel = din2;
      default: din_sel = din3;
    endcase
  end

  assign busy = (state == ST_GRANT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      sel        <= '0;
      hold_cnt   <= '0;
      last       <= SEL_W'(NUM_REQ - 1);
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= |gnt;
      if (|gnt) begin
        dout <= din_sel;
      end

      if (state == ST_IDLE) begin
        if (found) begin
          gnt      <= to_onehot(pick);
          sel      <= pick;
          hold_cnt <= '0;
          state    <= ST_GRANT;
        end
      end else begin
        if (!req[sel]) begin
          // Owner released: hand over directly, or fall back to idle.
          last     <= sel;
          hold_cnt <= '0;
          if (found) begin
            gnt <= to_onehot(pick);
            sel <= pick;
          end else begin
            gnt   <= '0;
            state <= ST_IDLE;
          end
        end else if (hold_cnt == HOLD_LAST && found) begin
          last     <= sel;
          gnt      <= to_onehot(pick);
          sel      <= pick;
          hold_cnt <= '0;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed vector table, corner sequences, random stress.
module tb_mux4_rr_arbiter;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned MAX_HOLD   = 4;
  localparam int          STARVE_MAX = 3 * int'(MAX_HOLD);
  localparam int          NVEC       = 26;

  logic             clock;
  logic             reset;
  logic [3:0]       req;
  logic [WIDTH-1:0] din0, din1, din2, din3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       dv;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [NVEC];

  // Reference model state for the stress run.
  logic       m_busy;
  logic [1:0] m_sel;
  logic [1:0] m_last;
  int         m_hold;
  logic [3:0] m_gnt;
  logic [7:0] m_dout;
  logic       m_dv;
  int         waitc [4];

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic v, input logic [7:0] d);
    vec_t x;
    x.req  = r;
    x.gnt  = g;
    x.sel  = s;
    x.busy = b;
    x.dv   = v;
    x.dout = d;
    return x;
  endfunction

  function automatic int first_from(input logic [3:0] r, input int after, input int skip);
    for (int n = 1; n <= 4; n++) begin
      int c;
      c = (after + n) % 4;
      if (r[c] && c != skip) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_din(input logic [1:0] s);
    case (s)
      2'd0:    return din0;
      2'd1:    return din1;
      2'd2:    return din2;
      default: return din3;
    endcase
  endfunction

  task automatic model_grant(input int p);
    m_busy = 1'b1;
    m_sel  = 2'(p);
    m_gnt  = 4'(1 << p);
    m_hold = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_step();
    int p;
    m_dv = (m_gnt != 4'b0);
    if (m_gnt != 4'b0) m_dout = model_din(m_sel);
    if (!m_busy) begin
      p = first_from(req, int'(m_last), -1);
      if (p >= 0) model_grant(p);
    end else begin
      p = first_from(req, int'(m_sel), int'(m_sel));
      if (!req[m_sel]) begin
        m_last = m_sel;
        if (p >= 0) model_grant(p);
        else begin
          m_busy = 1'b0;
          m_gnt  = 4'b0;
          m_hold = 0;
        end
      end else if (m_hold == int'(MAX_HOLD) - 1 && p >= 0) begin
        m_last = m_sel;
        model_grant(p);
      end else if (m_hold < int'(MAX_HOLD) - 1) begin
        m_hold++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0;
    din0  = 8'h10;
    din1  = 8'hA5;
    din2  = 8'h32;
    din3  = 8'h43;

    // req, gnt, sel, busy, dout_valid, dout -- from reset (last=3)
    vecs[0]  = mk(4'hF, 4'h1, 2'd0, 1, 0, 8'h00);
    vecs[1]  = mk(4'hF, 4'h1, 2'd0, 1, 1, 8'h10);
    vecs[2]  = mk(4'hF, 4'h1, 2'd0, 1, 1, 8'h10);
    vecs[3]  = mk(4'hF, 4'h1, 2'd0, 1, 1, 8'h10);
    vecs[4]  = mk(4'hF, 4'h2, 2'd1, 1, 1, 8'h10);
    vecs[5]  = mk(4'hF, 4'h2, 2'd1, 1, 1, 8'hA5);
    vecs[6]  = mk(4'hF, 4'h2, 2'd1, 1, 1, 8'hA5);
    vecs[7]  = mk(4'hF, 4'h2, 2'd1, 1, 1, 8'hA5);
    vecs[8]  = mk(4'hF, 4'h4, 2'd2, 1, 1, 8'hA5);
    vecs[9]  = mk(4'hF, 4'h4, 2'd2, 1, 1, 8'h32);
    vecs[10] = mk(4'hF, 4'h4, 2'd2, 1, 1, 8'h32);
    vecs[11] = mk(4'hF, 4'h4, 2'd2, 1, 1, 8'h32);
    vecs[12] = mk(4'hF, 4'h8, 2'd3, 1, 1, 8'h32);
    vecs[13] = mk(4'hF, 4'h8, 2'd3, 1, 1, 8'h43);
    vecs[14] = mk(4'hF, 4'h8, 2'd3, 1, 1, 8'h43);
    vecs[15] = mk(4'hF, 4'h8, 2'd3, 1, 1, 8'h43);
    vecs[16] = mk(4'hF, 4'h1, 2'd0, 1, 1, 8'h43);
    vecs[17] = mk(4'h8, 4'h8, 2'd3, 1, 1, 8'h10);
    vecs[18] = mk(4'h4, 4'h4, 2'd2, 1, 1, 8'h43);
    vecs[19] = mk(4'h3, 4'h1, 2'd0, 1, 1, 8'h32);
    vecs[20] = mk(4'h0, 4'h0, 2'd0, 0, 1, 8'h10);
    vecs[21] = mk(4'h0, 4'h0, 2'd0, 0, 0, 8'h10);
    vecs[22] = mk(4'h3, 4'h2, 2'd1, 1, 0, 8'h10);
    vecs[23] = mk(4'h1, 4'h1, 2'd0, 1, 1, 8'hA5);
    vecs[24] = mk(4'h0, 4'h0, 2'd0, 0, 1, 8'h10);
    vecs[25] = mk(4'h0, 4'h0, 2'd0, 0, 0, 8'h10);

    step();
    step();
    check("reset.gnt",  32'(gnt),        32'h0);
    check("reset.sel",  32'(sel),        32'h0);
    check("reset.dout", 32'(dout),       32'h0);
    check("reset.dv",   32'(dout_valid), 32'h0);
    check("reset.busy", 32'(busy),       32'h0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      req = vecs[i].req;
      step();
      check($sformatf("v%0d.gnt", i),  32'(gnt),        32'(vecs[i].gnt));
      check($sformatf("v%0d.sel", i),  32'(sel),        32'(vecs[i].sel));
      check($sformatf("v%0d.busy", i), 32'(busy),       32'(vecs[i].busy));
      check($sformatf("v%0d.dv", i),   32'(dout_valid), 32'(vecs[i].dv));
      check($sformatf("v%0d.dout", i), 32'(dout),       32'(vecs[i].dout));
    end

    // Sole requester holds indefinitely.
    req = 4'b0010;
    step();
    check("single.gnt", 32'(gnt), 32'h2);
    check("single.sel", 32'(sel), 32'h1);
    step();
    check("single.dout", 32'(dout),       32'hA5);
    check("single.dv",   32'(dout_valid), 32'h1);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("single.hold%0d", i), 32'(gnt), 32'h2);
    end

    // Asynchronous reset while requester 2 owns the grant.
    req = 4'b0100;
    step();
    check("rstmid.pre_gnt", 32'(gnt), 32'h4);
    reset = 1'b1;
    #1;
    check("rstmid.gnt",  32'(gnt),        32'h0);
    check("rstmid.sel",  32'(sel),        32'h0);
    check("rstmid.dout", 32'(dout),       32'h0);
    check("rstmid.dv",   32'(dout_valid), 32'h0);
    check("rstmid.busy", 32'(busy),       32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    req   = 4'b1111;
    step();
    check("rstmid.after_gnt", 32'(gnt), 32'h1);
    check("rstmid.after_sel", 32'(sel), 32'h0);

    // Random stress against the reference model.
    req   = 4'b0;
    reset = 1'b1;
    step();
    reset  = 1'b0;
    m_busy = 1'b0;
    m_sel  = 2'd0;
    m_last = 2'd3;
    m_hold = 0;
    m_gnt  = 4'b0;
    m_dout = 8'h00;
    m_dv   = 1'b0;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      din0 = 8'($urandom);
      din1 = 8'($urandom);
      din2 = 8'($urandom);
      din3 = 8'($urandom);
      for (int b = 0; b < 4; b++) begin
        if (req[b] && !gnt[b]) waitc[b]++;
        else waitc[b] = 0;
        check($sformatf("stress.starve%0d", b), 32'(waitc[b] > STARVE_MAX), 32'h0);
      end
      model_step();
      step();
      check("stress.onehot", 32'($onehot0(gnt)), 32'h1);
      check("stress.gnt",    32'(gnt),        32'(m_gnt));
      check("stress.sel",    32'(sel),        32'(m_sel));
      check("stress.busy",   32'(busy),       32'(m_busy));
      check("stress.dv",     32'(dout_valid), 32'(m_dv));
      check("stress.dout",   32'(dout),       32'(m_dout));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
